// File: rtl/axi_sram_responder_pkg.sv
// Shared AXI definitions for the SRAM responder: bus widths and burst encodings.
package axi_sram_responder_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_type_t;

    // Only FIXED holds the word index; WRAP and the reserved code step like INCR.
    function automatic logic burst_advances(axi_burst_type_t burst);
        return burst != AXI_BURST_FIXED;
    endfunction

endpackage

// File: rtl/axi4_interface.sv
// AXI4 bus between the core-side master and a slave; m_* driven by master, s_* by slave.
interface axi4_interface;
    import axi_sram_responder_pkg::*;

    logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]                m_awlen;
    logic [2:0]                m_awsize;
    axi_burst_type_t           m_awburst;
    logic                      m_awvalid;
    logic                      s_awready;

    logic [AXI_DATA_WIDTH-1:0] m_wdata;
    logic [AXI_STRB_WIDTH-1:0] m_wstrb;
    logic                      m_wlast;
    logic                      m_wvalid;
    logic                      s_wready;

    logic [1:0]                s_bresp;
    logic                      s_bvalid;
    logic                      m_bready;

    logic [AXI_ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]                m_arlen;
    logic [2:0]                m_arsize;
    axi_burst_type_t           m_arburst;
    logic                      m_arvalid;
    logic                      s_arready;

    logic [AXI_DATA_WIDTH-1:0] s_rdata;
    logic [1:0]                s_rresp;
    logic                      s_rlast;
    logic                      s_rvalid;
    logic                      m_rready;

    modport master (
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  s_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  s_wready,
        input  s_bresp, s_bvalid,
        output m_bready,
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  s_arready,
        input  s_rdata, s_rresp, s_rlast, s_rvalid,
        output m_rready
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output s_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output s_wready,
        output s_bresp, s_bvalid,
        input  m_bready,
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output s_arready,
        output s_rdata, s_rresp, s_rlast, s_rvalid,
        input  m_rready
    );

endinterface

// File: rtl/axi_stall_lfsr.sv
// Random wait-state generator for the SRAM responder. Compiled only when
// AXI_SRAM_STALL_EN is defined; stall is high on roughly one cycle in four.
`ifdef AXI_SRAM_STALL_EN
module axi_stall_lfsr (
    input  logic clk,
    input  logic reset,
    output logic stall
);

    logic [15:0] lfsr_q;
    logic        feedback;

    // Fibonacci taps 16,14,13,11
    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Free-running shift register, reseeded on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);

endmodule
`endif

// File: rtl/axi_sram_responder.sv
// AXI4 slave serving one burst at a time from an internal word-addressed SRAM.
// Optional random wait states: define AXI_SRAM_STALL_EN.
module axi_sram_responder
    import axi_sram_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 'h40000
) (
    input logic          clk,
    input logic          reset,
    axi4_interface.slave axi_bus
);

    localparam int unsigned ByteBits  = $clog2(AXI_STRB_WIDTH);
    localparam int unsigned AddrBits  = $clog2(MEM_WORDS);
    localparam int          StrbBytes = int'(AXI_STRB_WIDTH);

    typedef logic [AddrBits-1:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StReadBurst,
        StWriteBurst,
        StWriteResp
    } state_e;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_e                    state_q, state_d;
    logic                      last_was_write_q, last_was_write_d;
    logic [7:0]                count_q, count_d;
    word_t                     word_q, word_d;
    axi_burst_type_t           burst_q, burst_d;
    logic                      rvalid_q, rvalid_d;
    logic                      rd_first_q, rd_first_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic stall;
    logic grant_w, grant_r;
    logic wr_en, fetch;
    logic awready, arready, wready, bvalid, rvalid;

`ifdef AXI_SRAM_STALL_EN
    axi_stall_lfsr u_stall_lfsr (
        .clk   (clk),
        .reset (reset),
        .stall (stall)
    );
`else
    assign stall = 1'b0;
`endif

    // Arbitration, burst sequencing and handshake outputs
    always_comb begin
        state_d          = state_q;
        last_was_write_d = last_was_write_q;
        count_d          = count_q;
        word_d           = word_q;
        burst_d          = burst_q;
        rvalid_d         = rvalid_q;
        rd_first_d       = rd_first_q;
        grant_w          = 1'b0;
        grant_r          = 1'b0;
        wr_en            = 1'b0;
        fetch            = 1'b0;
        awready          = 1'b0;
        arready          = 1'b0;
        wready           = 1'b0;
        bvalid           = 1'b0;
        rvalid           = 1'b0;

        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    // On contention the channel not granted last time wins
                    grant_w = axi_bus.m_awvalid && (!axi_bus.m_arvalid || !last_was_write_q);
                    grant_r = axi_bus.m_arvalid && !grant_w;
                    awready = grant_w;
                    arready = grant_r;
                    if (grant_w) begin
                        state_d          = StWriteBurst;
                        last_was_write_d = 1'b1;
                        count_d          = axi_bus.m_awlen;
                        word_d           = axi_bus.m_awaddr[ByteBits +: AddrBits];
                        burst_d          = axi_bus.m_awburst;
                    end else if (grant_r) begin
                        state_d          = StReadBurst;
                        last_was_write_d = 1'b0;
                        count_d          = axi_bus.m_arlen;
                        word_d           = axi_bus.m_araddr[ByteBits +: AddrBits];
                        burst_d          = axi_bus.m_arburst;
                        rd_first_d       = 1'b1;
                    end
                end
                StWriteBurst: begin
                    wready = !stall;
                    if (axi_bus.m_wvalid && wready) begin
                        wr_en = 1'b1;
                        if (count_q == 8'd0) begin
                            state_d = StWriteResp;
                        end else begin
                            count_d = count_q - 8'd1;
                            if (burst_advances(burst_q)) begin
                                word_d = word_q + word_t'(1);
                            end
                        end
                    end
                end
                StWriteResp: begin
                    bvalid = !stall;
                    if (bvalid && axi_bus.m_bready) begin
                        state_d = StIdle;
                    end
                end
                StReadBurst: begin
                    rvalid = rvalid_q && !stall;
                    if (rd_first_q) begin
                        fetch      = 1'b1;
                        rd_first_d = 1'b0;
                        rvalid_d   = 1'b1;
                    end else if (rvalid && axi_bus.m_rready) begin
                        if (count_q == 8'd0) begin
                            state_d  = StIdle;
                            rvalid_d = 1'b0;
                        end else begin
                            count_d = count_q - 8'd1;
                            fetch   = 1'b1;
                        end
                    end
                    // word_q always names the next word to fetch
                    if (fetch && burst_advances(burst_q)) begin
                        word_d = word_q + word_t'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            last_was_write_q <= 1'b0;
            count_q          <= 8'd0;
            word_q           <= '0;
            burst_q          <= AXI_BURST_FIXED;
            rvalid_q         <= 1'b0;
            rd_first_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_was_write_q <= last_was_write_d;
            count_q          <= count_d;
            word_q           <= word_d;
            burst_q          <= burst_d;
            rvalid_q         <= rvalid_d;
            rd_first_q       <= rd_first_d;
        end
    end

    // Byte-enabled write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < StrbBytes; b++) begin
                if (axi_bus.m_wstrb[b]) begin
                    mem[word_q][b*8 +: 8] <= axi_bus.m_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Synchronous read port; holds its value until the next fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (fetch) begin
            rdata_q <= mem[word_q];
        end
    end

    assign axi_bus.s_awready = awready;
    assign axi_bus.s_arready = arready;
    assign axi_bus.s_wready  = wready;
    assign axi_bus.s_bvalid  = bvalid;
    assign axi_bus.s_bresp   = 2'b00;
    assign axi_bus.s_rvalid  = rvalid;
    assign axi_bus.s_rdata   = rdata_q;
    assign axi_bus.s_rresp   = 2'b00;
    assign axi_bus.s_rlast   = rvalid && (count_q == 8'd0);

    // Size fields, out-of-range address bits and wlast do not affect behaviour
    logic unused_inputs;
    assign unused_inputs = ^{axi_bus.m_awsize, axi_bus.m_arsize, axi_bus.m_awaddr,
                             axi_bus.m_araddr, axi_bus.m_wlast};

`ifndef SYNTHESIS
    // Termination uses the beat count; a disagreeing wlast points at a broken master
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            assert (axi_bus.m_wlast == (count_q == 8'd0))
            else $error("axi_sram_responder: m_wlast=%0b with %0d beats remaining",
                        axi_bus.m_wlast, count_q);
        end
    end
`endif

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a read-data scoreboard.
module tb_axi_sram_responder;
    import axi_sram_responder_pkg::*;

    localparam int unsigned MemWords = 'h40000;
    localparam int          Budget   = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi4_interface bus ();

    axi_sram_responder #(
        .MEM_WORDS (MemWords)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .axi_bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [31:0] wq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) & (MemWords - 1));
    endfunction

    // Called at a negedge; returns at the negedge after the B handshake
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input axi_burst_type_t burst, input logic [3:0] strb);
        int          w;
        int          cyc;
        int          waits;
        logic [31:0] tmp;
        bus.m_awaddr  = addr;
        bus.m_awlen   = len;
        bus.m_awsize  = 3'd2;
        bus.m_awburst = burst;
        bus.m_awvalid = 1'b1;
        #1;
        cyc = 0;
        while (!bus.s_awready && cyc < Budget) begin
            @(negedge clk); #1; cyc++;
        end
        check("aw_grant", 32'(bus.s_awready), 32'd1);
        @(negedge clk);
        bus.m_awvalid = 1'b0;
        #1 check("w_ready_a1", 32'(bus.s_wready), 32'd1);
        w     = word_of(addr);
        waits = 0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.m_wdata  = wq[i];
            bus.m_wstrb  = strb;
            bus.m_wlast  = (i == int'(len));
            bus.m_wvalid = 1'b1;
            #1;
            cyc = 0;
            while (!bus.s_wready && cyc < Budget) begin
                @(negedge clk); #1; cyc++;
            end
            waits += cyc;
            tmp = model.exists(w) ? model[w] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) tmp[b*8 +: 8] = wq[i][b*8 +: 8];
            end
            model[w] = tmp;
            if (burst != AXI_BURST_FIXED) w = (w + 1) % int'(MemWords);
            @(negedge clk);
        end
        check("w_no_waits", 32'(waits), 32'd0);
        bus.m_wvalid = 1'b0;
        bus.m_wlast  = 1'b0;
        #1 check("b_valid_l1", 32'(bus.s_bvalid), 32'd1);
        bus.m_bready = 1'b1;
        cyc = 0;
        while (!bus.s_bvalid && cyc < Budget) begin
            @(negedge clk); #1; cyc++;
        end
        @(negedge clk);
        bus.m_bready = 1'b0;
    endtask

    // Called at a negedge; pushes expected beats, then drains them against the DUT
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input axi_burst_type_t burst, input bit toggle);
        int          w;
        int          cyc;
        int          beats;
        bit          phase;
        bit          held;
        logic [31:0] held_data;
        logic [31:0] exp;
        w = word_of(addr);
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(model[w]);
            if (burst != AXI_BURST_FIXED) w = (w + 1) % int'(MemWords);
        end
        bus.m_araddr  = addr;
        bus.m_arlen   = len;
        bus.m_arsize  = 3'd2;
        bus.m_arburst = burst;
        bus.m_arvalid = 1'b1;
        #1;
        cyc = 0;
        while (!bus.s_arready && cyc < Budget) begin
            @(negedge clk); #1; cyc++;
        end
        check("ar_grant", 32'(bus.s_arready), 32'd1);
        @(negedge clk);
        bus.m_arvalid = 1'b0;
        #1 check("r_idle_a1", 32'(bus.s_rvalid), 32'd0);
        @(negedge clk);
        #1 check("r_first_a2", 32'(bus.s_rvalid), 32'd1);
        beats = 0;
        cyc   = 0;
        phase = 1'b0;
        held  = 1'b0;
        held_data = '0;
        while (beats <= int'(len) && cyc < Budget) begin
            bus.m_rready = toggle ? phase : 1'b1;
            #1;
            if (bus.s_rvalid) begin
                if (held) check("r_hold", bus.s_rdata, held_data);
                if (bus.m_rready) begin
                    exp = exp_q.pop_front();
                    check("r_data", bus.s_rdata, exp);
                    check("r_last", 32'(bus.s_rlast), 32'(beats == int'(len)));
                    beats++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = bus.s_rdata;
                end
            end
            phase = !phase;
            @(negedge clk);
            cyc++;
        end
        bus.m_rready = 1'b0;
        check("r_beats", 32'(beats), 32'(len) + 32'd1);
        #1 check("r_done_idle", 32'(bus.s_rvalid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.m_awaddr  = '0;
        bus.m_awlen   = '0;
        bus.m_awsize  = '0;
        bus.m_awburst = AXI_BURST_INCR;
        bus.m_awvalid = 1'b1;
        bus.m_wdata   = '0;
        bus.m_wstrb   = '0;
        bus.m_wlast   = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_bready  = 1'b0;
        bus.m_araddr  = '0;
        bus.m_arlen   = '0;
        bus.m_arsize  = '0;
        bus.m_arburst = AXI_BURST_INCR;
        bus.m_arvalid = 1'b1;
        bus.m_rready  = 1'b0;

        // Outputs held at zero during reset even with requests pending
        repeat (3) @(negedge clk);
        #1;
        check("rst_handshakes", 32'({bus.s_awready, bus.s_arready, bus.s_wready,
                                     bus.s_bvalid, bus.s_rvalid, bus.s_rlast}), 32'd0);
        check("rst_rdata", bus.s_rdata, 32'd0);
        bus.m_awvalid = 1'b0;
        bus.m_arvalid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("idle_quiet", 32'({bus.s_awready, bus.s_arready, bus.s_wready,
                                    bus.s_bvalid, bus.s_rvalid}), 32'd0);
        @(negedge clk);

        // Single-beat write then read
        wq = '{32'hDEADBEEF};
        write_burst(32'h100, 8'd0, AXI_BURST_INCR, 4'hF);
        read_burst(32'h100, 8'd0, AXI_BURST_INCR, 1'b0);

        // Partial strobe merge: expect 11BB33DD
        wq = '{32'h11223344};
        write_burst(32'h200, 8'd0, AXI_BURST_INCR, 4'hF);
        wq = '{32'hAABBCCDD};
        write_burst(32'h200, 8'd0, AXI_BURST_INCR, 4'b0101);
        read_burst(32'h200, 8'd0, AXI_BURST_INCR, 1'b0);

        // 16-beat INCR, read back with toggling rready, then at full rate
        wq = {};
        for (int i = 0; i < 16; i++) wq.push_back(32'(i));
        write_burst(32'h1000, 8'd15, AXI_BURST_INCR, 4'hF);
        read_burst(32'h1000, 8'd15, AXI_BURST_INCR, 1'b1);
        read_burst(32'h1000, 8'd15, AXI_BURST_INCR, 1'b0);

        // FIXED burst: last beat wins
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        write_burst(32'h40, 8'd3, AXI_BURST_FIXED, 4'hF);
        read_burst(32'h40, 8'd0, AXI_BURST_INCR, 1'b0);
        read_burst(32'h40, 8'd2, AXI_BURST_FIXED, 1'b0);

        // INCR wrap off the top of the array
        wq = '{32'hA5A50001, 32'hA5A50002};
        write_burst(32'hFFFFC, 8'd1, AXI_BURST_INCR, 4'hF);
        read_burst(32'h0, 8'd0, AXI_BURST_INCR, 1'b0);
        read_burst(32'hFFFFC, 8'd1, AXI_BURST_INCR, 1'b0);

        // WRAP encoding steps like INCR
        wq = '{32'h0BAD0000, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003};
        write_burst(32'h2000, 8'd3, AXI_BURST_WRAP, 4'hF);
        read_burst(32'h2000, 8'd3, AXI_BURST_INCR, 1'b0);

        // Reset in the middle of an 8-beat read
        bus.m_araddr  = 32'h1000;
        bus.m_arlen   = 8'd7;
        bus.m_arburst = AXI_BURST_INCR;
        bus.m_arvalid = 1'b1;
        #1 check("mid_ar_grant", 32'(bus.s_arready), 32'd1);
        @(negedge clk);
        bus.m_arvalid = 1'b0;
        @(negedge clk);
        bus.m_rready = 1'b1;
        #1 check("mid_first_beat", bus.s_rdata, 32'd0);
        @(negedge clk);
        bus.m_rready = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        #1 check("mid_rst_rvalid", 32'(bus.s_rvalid), 32'd0);
        reset = 1'b0;

        // Contention straight after reset goes to write, then alternates
        bus.m_awaddr  = 32'h300;
        bus.m_awlen   = 8'd0;
        bus.m_awburst = AXI_BURST_INCR;
        bus.m_awvalid = 1'b1;
        bus.m_araddr  = 32'h300;
        bus.m_arlen   = 8'd0;
        bus.m_arburst = AXI_BURST_INCR;
        bus.m_arvalid = 1'b1;
        #1 check("contend_1st", 32'({bus.s_awready, bus.s_arready}), 32'b10);
        bus.m_arvalid = 1'b0;
        wq = '{32'hCAFEF00D};
        write_burst(32'h300, 8'd0, AXI_BURST_INCR, 4'hF);
        bus.m_awvalid = 1'b1;
        bus.m_arvalid = 1'b1;
        #1 check("contend_2nd", 32'({bus.s_awready, bus.s_arready}), 32'b01);
        bus.m_awvalid = 1'b0;
        read_burst(32'h300, 8'd0, AXI_BURST_INCR, 1'b0);
        bus.m_awvalid = 1'b1;
        bus.m_arvalid = 1'b1;
        #1 check("contend_3rd", 32'({bus.s_awready, bus.s_arready}), 32'b10);
        bus.m_awvalid = 1'b0;
        bus.m_arvalid = 1'b0;
        @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
